// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the integer register file.
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  // Address width for a register count (always at least one bit).
  function automatic int addrWidth(input int nRegs);
    return (nRegs <= 2) ? 1 : $clog2(nRegs);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ID/WB-facing bus of the register file: read ports, WB write, issue.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = 2
);
  localparam int AW = addrWidth(NREGS);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                any_busy;

  modport master (
    output rd_addr, we, waddr, wdata, iss_valid, iss_rd,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, we, waddr, wdata, iss_valid, iss_rd,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port with write-through bypass and hazard flag.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ZERO_R0 = 1,
  localparam int AW     = addrWidth(NREGS)
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] data,
  output logic            busyOut
);
  logic isZero;
  logic wrHit;

  // A same-cycle writeback both forwards its data and resolves the hazard.
  always_comb begin
    isZero  = (ZERO_R0 != 0) && (addr == AW'(REG_ZERO));
    wrHit   = we && (waddr == addr);
    if (isZero)
      data = '0;
    else if (wrHit)
      data = wdata;
    else
      data = regs[addr];
    busyOut = !isZero && busy[addr] && !wrHit;
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with N bypassed read ports and a
// per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = addrWidth(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;
  logic             wrIsZero;
  logic             issIsZero;

  assign wrIsZero  = (ZERO_R0 != 0) && (bus.waddr == AW'(REG_ZERO));
  assign issIsZero = (ZERO_R0 != 0) && (bus.iss_rd == AW'(REG_ZERO));

  // Register storage: reset clears every entry; writes to a hardwired x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.we && !wrIsZero) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard next state: the issue set is applied after the WB clear so a
  // new producer on the retiring register keeps it busy.
  always_comb begin
    busyNext = busy;
    if (bus.we) busyNext[bus.waddr] = 1'b0;
    if (bus.iss_valid && !issIsZero) busyNext[bus.iss_rd] = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busyNext;
  end

  assign bus.any_busy = |busy;

  for (genvar g = 0; g < NRP; g++) begin : gRdPort
    regfile_sb_rdport #(
      .XLEN    (XLEN),
      .NREGS   (NREGS),
      .ZERO_R0 (ZERO_R0)
    ) uRdPort (
      .addr    (bus.rd_addr[g*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .we      (bus.we),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .data    (bus.rd_data[g*XLEN +: XLEN]),
      .busyOut (bus.rd_busy[g])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Two configurations side by side: default (32x32, 2 ports, x0 hardwired)
// and wide (64x64, 4 ports, x0 ordinary).
module tb_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRP(2)) bus0 ();
  regfile_sb_if #(.XLEN(64), .NREGS(64), .NRP(4)) bus1 ();

  logic [1:0]  rstV;
  logic [1:0]  weV, issV;
  logic [5:0]  waddrV [2];
  logic [5:0]  issRdV [2];
  logic [63:0] wdataV [2];
  logic [5:0]  rdAddrV [2][4];

  regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2), .ZERO_R0(1)) dut0 (
    .clk (clk), .rst (rstV[0]), .bus (bus0.slave));
  regfile_sb #(.XLEN(64), .NREGS(64), .NRP(4), .ZERO_R0(0)) dut1 (
    .clk (clk), .rst (rstV[1]), .bus (bus1.slave));

  assign bus0.we        = weV[0];
  assign bus0.waddr     = waddrV[0][4:0];
  assign bus0.wdata     = wdataV[0][31:0];
  assign bus0.iss_valid = issV[0];
  assign bus0.iss_rd    = issRdV[0][4:0];
  assign bus0.rd_addr   = {rdAddrV[0][1][4:0], rdAddrV[0][0][4:0]};
  assign bus1.we        = weV[1];
  assign bus1.waddr     = waddrV[1];
  assign bus1.wdata     = wdataV[1];
  assign bus1.iss_valid = issV[1];
  assign bus1.iss_rd    = issRdV[1];
  assign bus1.rd_addr   = {rdAddrV[1][3], rdAddrV[1][2], rdAddrV[1][1], rdAddrV[1][0]};

  int nRegs [2] = '{32, 64};
  int nPorts[2] = '{2, 4};
  bit zeroR0[2] = '{1'b1, 1'b0};

  // Behavioural model: architectural contents and outstanding producers.
  logic [63:0] mRegs [2][64];
  bit          mBusy [2][64];

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dutData(input int d, input int p);
    if (d == 0) return {32'b0, bus0.rd_data[p*32 +: 32]};
    return bus1.rd_data[p*64 +: 64];
  endfunction

  function automatic logic dutBusy(input int d, input int p);
    if (d == 0) return bus0.rd_busy[p];
    return bus1.rd_busy[p];
  endfunction

  function automatic logic dutAny(input int d);
    return (d == 0) ? bus0.any_busy : bus1.any_busy;
  endfunction

  function automatic logic [63:0] expData(input int d, input int p);
    int a = int'(rdAddrV[d][p]);
    if (zeroR0[d] && a == 0) return 64'd0;
    if (weV[d] && int'(waddrV[d]) == a) return wdataV[d];
    return mRegs[d][a];
  endfunction

  function automatic logic expBusy(input int d, input int p);
    int a = int'(rdAddrV[d][p]);
    if (zeroR0[d] && a == 0) return 1'b0;
    if (weV[d] && int'(waddrV[d]) == a) return 1'b0;
    return mBusy[d][a];
  endfunction

  function automatic logic expAny(input int d);
    for (int r = 0; r < nRegs[d]; r++) if (mBusy[d][r]) return 1'b1;
    return 1'b0;
  endfunction

  // Model state advances on each rising edge from the inputs of that cycle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstV[d]) begin
        for (int r = 0; r < 64; r++) begin
          mRegs[d][r] = 64'd0;
          mBusy[d][r] = 1'b0;
        end
      end else begin
        if (weV[d] && !(zeroR0[d] && waddrV[d] == 6'd0)) mRegs[d][waddrV[d]] = wdataV[d];
        if (weV[d]) mBusy[d][waddrV[d]] = 1'b0;
        if (issV[d] && !(zeroR0[d] && issRdV[d] == 6'd0)) mBusy[d][issRdV[d]] = 1'b1;
      end
    end
  end

  // Every cycle, all read ports and any_busy are compared against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < nPorts[d]; p++) begin
          chk($sformatf("cmp_data d%0d p%0d", d, p), dutData(d, p), expData(d, p));
          chk($sformatf("cmp_busy d%0d p%0d", d, p), 64'(dutBusy(d, p)), 64'(expBusy(d, p)));
        end
        chk($sformatf("cmp_any d%0d", d), 64'(dutAny(d)), 64'(expAny(d)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    weV  = 2'b00;
    issV = 2'b00;
    rstV = 2'b00;
  endtask

  initial begin
    rstV = 2'b11;
    weV  = 2'b00;
    issV = 2'b00;
    for (int d = 0; d < 2; d++) begin
      waddrV[d] = '0;
      issRdV[d] = '0;
      wdataV[d] = '0;
      for (int p = 0; p < 4; p++) rdAddrV[d][p] = '0;
    end
    step();
    idle();
    checkEn = 1'b1;
    #1;
    chk("reset_data0", dutData(0, 0), 64'd0);
    chk("reset_any1", 64'(dutAny(1)), 64'd0);

    // Reset clears a written register.
    weV[0] = 1'b1; waddrV[0] = 6'd5; wdataV[0] = 64'hDEADBEEF;
    step();
    idle(); rdAddrV[0][0] = 6'd5;
    #1 chk("x5_written", dutData(0, 0), 64'hDEADBEEF);
    rstV[0] = 1'b1;
    step();
    idle();
    #1;
    chk("x5_after_rst", dutData(0, 0), 64'd0);
    chk("x5_busy_after_rst", 64'(dutBusy(0, 0)), 64'd0);
    chk("any_after_rst", 64'(dutAny(0)), 64'd0);

    // Same-cycle bypass, then the stored value.
    weV[0] = 1'b1; waddrV[0] = 6'd7; wdataV[0] = 64'h12345678; rdAddrV[0][0] = 6'd7;
    #1 chk("bypass_x7", dutData(0, 0), 64'h12345678);
    step();
    idle();
    #1 chk("stored_x7", dutData(0, 0), 64'h12345678);

    // x0 hardwired (dut0) versus ordinary (dut1).
    weV = 2'b11; issV = 2'b11;
    for (int d = 0; d < 2; d++) begin
      waddrV[d] = 6'd0; wdataV[d] = 64'hFFFFFFFF; issRdV[d] = 6'd0; rdAddrV[d][0] = 6'd0;
    end
    #1 chk("x0_bypass_zero", dutData(0, 0), 64'd0);
    step();
    idle();
    #1;
    chk("x0_hard_data", dutData(0, 0), 64'd0);
    chk("x0_hard_busy", 64'(dutBusy(0, 0)), 64'd0);
    chk("x0_hard_any", 64'(dutAny(0)), 64'd0);
    chk("x0_plain_data", dutData(1, 0), 64'hFFFFFFFF);
    chk("x0_plain_busy", 64'(dutBusy(1, 0)), 64'd1);

    // Scoreboard: issue x3, then resolve it with a writeback.
    issV[0] = 1'b1; issRdV[0] = 6'd3;
    step();
    idle(); rdAddrV[0][0] = 6'd3;
    #1;
    chk("x3_busy", 64'(dutBusy(0, 0)), 64'd1);
    chk("x3_any", 64'(dutAny(0)), 64'd1);
    weV[0] = 1'b1; waddrV[0] = 6'd3; wdataV[0] = 64'hA5;
    #1;
    chk("x3_wb_busy", 64'(dutBusy(0, 0)), 64'd0);
    chk("x3_wb_data", dutData(0, 0), 64'hA5);
    chk("x3_wb_any_still", 64'(dutAny(0)), 64'd1);
    step();
    idle();
    #1;
    chk("x3_cleared", 64'(dutBusy(0, 0)), 64'd0);
    chk("x3_any_cleared", 64'(dutAny(0)), 64'd0);

    // Simultaneous clear and set on the same register: set wins.
    issV[0] = 1'b1; issRdV[0] = 6'd9;
    step();
    weV[0] = 1'b1; waddrV[0] = 6'd9; wdataV[0] = 64'h99; issV[0] = 1'b1; issRdV[0] = 6'd9;
    step();
    idle(); rdAddrV[0][0] = 6'd9;
    #1 chk("x9_set_wins", 64'(dutBusy(0, 0)), 64'd1);
    // Different registers: both take effect.
    weV[0] = 1'b1; waddrV[0] = 6'd9; wdataV[0] = 64'h9A; issV[0] = 1'b1; issRdV[0] = 6'd10;
    step();
    idle(); rdAddrV[0][1] = 6'd10;
    #1;
    chk("x9_cleared", 64'(dutBusy(0, 0)), 64'd0);
    chk("x10_set", 64'(dutBusy(0, 1)), 64'd1);
    weV[0] = 1'b1; waddrV[0] = 6'd10; wdataV[0] = 64'h10;
    step();
    idle();

    // Wide configuration: fill regs, read four ports, reset with a concurrent write.
    rstV[1] = 1'b1;
    step();
    idle();
    for (int i = 1; i < 64; i++) begin
      weV[1] = 1'b1; waddrV[1] = 6'(i); wdataV[1] = 64'(i * 3);
      step();
    end
    idle();
    rdAddrV[1][0] = 6'd0; rdAddrV[1][1] = 6'd17; rdAddrV[1][2] = 6'd42; rdAddrV[1][3] = 6'd63;
    #1;
    chk("wide_p0", dutData(1, 0), 64'd0);
    chk("wide_p1", dutData(1, 1), 64'd51);
    chk("wide_p2", dutData(1, 2), 64'd126);
    chk("wide_p3", dutData(1, 3), 64'd189);
    chk("model_pin_x42", mRegs[1][42], 64'd126);
    rstV[1] = 1'b1; weV[1] = 1'b1; waddrV[1] = 6'd17; wdataV[1] = 64'd999;
    step();
    idle();
    for (int i = 0; i < 64; i += 4) begin
      for (int p = 0; p < 4; p++) rdAddrV[1][p] = 6'(i + p);
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("wide_rst x%0d", i + p), dutData(1, p), 64'd0);
    end
    chk("model_pin_x17_rst", mRegs[1][17], 64'd0);

    // Randomized traffic; addresses biased low to provoke bypass and set/clear collisions.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        int lim = ($urandom_range(0, 1) == 1) ? 7 : nRegs[d] - 1;
        rstV[d]   = ($urandom_range(0, 199) == 0);
        weV[d]    = $urandom_range(0, 1) == 1;
        issV[d]   = $urandom_range(0, 2) != 0;
        waddrV[d] = 6'($urandom_range(0, lim));
        issRdV[d] = 6'($urandom_range(0, lim));
        wdataV[d] = (d == 0) ? {32'b0, 32'($urandom)} : {32'($urandom), 32'($urandom)};
        for (int p = 0; p < 4; p++)
          rdAddrV[d][p] = (p < nPorts[d]) ? 6'($urandom_range(0, lim)) : 6'd0;
      end
      step();
    end
    idle();
    step();
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
